// File: rtl/dino_motion_ctrl_pkg.sv
// Shared encodings for the dino sprite sequencer: FSM states and the sprite
// select codes that the drawDino renderer also decodes.
package dino_motion_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        DUCK = 3'd2,
        AIR  = 3'd3,
        DEAD = 3'd4
    } dino_state_t;

    localparam logic [3:0] SEL_STAND  = 4'd0;
    localparam logic [3:0] SEL_RUN_A  = 4'd1;
    localparam logic [3:0] SEL_RUN_B  = 4'd2;
    localparam logic [3:0] SEL_DUCK_A = 4'd3;
    localparam logic [3:0] SEL_DUCK_B = 4'd4;
    localparam logic [3:0] SEL_JUMP   = 4'd5;
    localparam logic [3:0] SEL_DEAD   = 4'd10;

    function automatic logic [3:0] sprite_for(dino_state_t st, logic phase);
        logic [3:0] sel;
        sel = SEL_STAND;
        case (st)
            IDLE:    sel = SEL_STAND;
            RUN:     sel = phase ? SEL_RUN_B : SEL_RUN_A;
            DUCK:    sel = phase ? SEL_DUCK_B : SEL_DUCK_A;
            AIR:     sel = SEL_JUMP;
            DEAD:    sel = SEL_DEAD;
            default: sel = SEL_STAND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dino_motion_ctrl_frame_tick_gen.sv
// Brings the pixel-domain vsync into the system clock domain and emits one
// single-cycle frame_tick per vsync falling edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_tick
);

    logic sync1;
    logic sync2;
    logic prev;

    // Idle level of vsync is high, so resetting to 1 avoids a spurious tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            prev       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= vsync;
            sync2      <= sync1;
            prev       <= sync2;
            frame_tick <= prev & ~sync2;
        end
    end

endmodule

// File: rtl/dino_motion_ctrl.sv
// Per-frame dino sequencer: state machine, jump physics and leg animation,
// producing the Y origin and sprite select for the sprite renderer.
module dino_motion_ctrl
    import dino_motion_ctrl_pkg::*;
#(
    parameter int GROUND_Y = 300,
    parameter int JUMP_V   = 16,
    parameter int GRAVITY  = 1,
    parameter int ANIM_DIV = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        jump_btn,
    input  logic        duck_btn,
    input  logic        game_over,
    output logic [31:0] dino_y,
    output logic [3:0]  dino_sel,
    output logic        airborne
);

    localparam logic [7:0]        ANIM_LAST = 8'(ANIM_DIV - 1);
    localparam logic signed [8:0] LAUNCH_V  = 9'(JUMP_V);
    localparam logic signed [8:0] GRAV_V    = 9'(GRAVITY);

    logic              frame_tick;
    dino_state_t       state, state_n;
    logic [8:0]        h, h_n;
    logic signed [8:0] vel, vel_n;
    logic [7:0]        anim_cnt, anim_n;
    logic              phase, phase_n;
    logic signed [9:0] h_sum;

    frame_tick_gen u_tick (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    // Collision wins on any edge; everything else advances only on a frame tick.
    always_comb begin
        state_n = state;
        h_n     = h;
        vel_n   = vel;
        anim_n  = anim_cnt;
        phase_n = phase;
        h_sum   = $signed({1'b0, h}) + $signed({vel[8], vel});

        if (game_over) begin
            state_n = DEAD;
        end else if (frame_tick) begin
            if (state == RUN || state == DUCK) begin
                if (anim_cnt == ANIM_LAST) begin
                    anim_n  = 8'd0;
                    phase_n = ~phase;
                end else begin
                    anim_n = anim_cnt + 8'd1;
                end
            end
            case (state)
                IDLE: if (jump_btn) state_n = RUN;
                RUN, DUCK: begin
                    if (jump_btn) begin
                        state_n = AIR;
                        vel_n   = LAUNCH_V;
                        h_n     = 9'd0;
                    end else if (state == RUN && duck_btn) begin
                        state_n = DUCK;
                    end else if (state == DUCK && !duck_btn) begin
                        state_n = RUN;
                    end
                end
                AIR: begin
                    if (h_sum <= 10'sd0) begin
                        h_n     = 9'd0;
                        vel_n   = 9'sd0;
                        state_n = duck_btn ? DUCK : RUN;
                    end else begin
                        h_n   = h_sum[8:0];
                        vel_n = vel - GRAV_V;
                    end
                end
                DEAD: begin
                    if (jump_btn) begin
                        state_n = RUN;
                        h_n     = 9'd0;
                        vel_n   = 9'sd0;
                        anim_n  = 8'd0;
                        phase_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are derived from the next-state values so they track the state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            h        <= 9'd0;
            vel      <= 9'sd0;
            anim_cnt <= 8'd0;
            phase    <= 1'b0;
            dino_y   <= 32'(GROUND_Y);
            dino_sel <= SEL_STAND;
            airborne <= 1'b0;
        end else begin
            state    <= state_n;
            h        <= h_n;
            vel      <= vel_n;
            anim_cnt <= anim_n;
            phase    <= phase_n;
            dino_y   <= 32'(GROUND_Y) - {23'd0, h_n};
            dino_sel <= sprite_for(state_n, phase_n);
            airborne <= (state_n == AIR);
        end
    end

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Self-checking bench for dino_motion_ctrl: directed frame sequences followed
// by random frames, compared against a frame-level behavioural model.
module tb_dino_motion_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vsync = 1'b1;
    logic        jump_btn = 1'b0;
    logic        duck_btn = 1'b0;
    logic        game_over = 1'b0;
    logic [31:0] dino_y;
    logic [3:0]  dino_sel;
    logic        airborne;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: integer posture code, height and speed per frame.
    localparam int P_STAND = 0, P_RUN = 1, P_DUCK = 2, P_AIR = 3, P_DEAD = 4;
    int mPost, mH, mV, mAnim, mPhase;

    dino_motion_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .jump_btn  (jump_btn),
        .duck_btn  (duck_btn),
        .game_over (game_over),
        .dino_y    (dino_y),
        .dino_sel  (dino_sel),
        .airborne  (airborne)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic j, input logic d, input logic g);
        @(negedge clk);
        jump_btn  = j;
        duck_btn  = d;
        game_over = g;
    endtask

    function automatic void modelReset();
        mPost = P_STAND; mH = 0; mV = 0; mAnim = 0; mPhase = 0;
    endfunction

    function automatic void modelFrame(input logic j, input logic d, input logic g);
        if (g) begin
            mPost = P_DEAD;
            return;
        end
        if (mPost == P_RUN || mPost == P_DUCK) begin
            mAnim = mAnim + 1;
            if (mAnim == 6) begin
                mAnim = 0;
                mPhase = 1 - mPhase;
            end
        end
        if (mPost == P_STAND) begin
            if (j) mPost = P_RUN;
        end else if (mPost == P_RUN || mPost == P_DUCK) begin
            if (j) begin
                mPost = P_AIR; mV = 16; mH = 0;
            end else begin
                mPost = d ? P_DUCK : P_RUN;
            end
        end else if (mPost == P_AIR) begin
            if (mH + mV <= 0) begin
                mH = 0; mV = 0;
                mPost = d ? P_DUCK : P_RUN;
            end else begin
                mH = mH + mV;
                mV = mV - 1;
            end
        end else if (j) begin
            mPost = P_RUN; mH = 0; mV = 0; mAnim = 0; mPhase = 0;
        end
    endfunction

    function automatic int modelSel();
        case (mPost)
            P_RUN:   return mPhase ? 2 : 1;
            P_DUCK:  return mPhase ? 4 : 3;
            P_AIR:   return 5;
            P_DEAD:  return 10;
            default: return 0;
        endcase
    endfunction

    task automatic checkModel(input string tag);
        checkOutput({tag, "_y"}, dino_y, 32'(300 - mH));
        checkOutput({tag, "_sel"}, {28'd0, dino_sel}, 32'(modelSel()));
        checkOutput({tag, "_air"}, {31'd0, airborne}, (mPost == P_AIR) ? 32'd1 : 32'd0);
    endtask

    // One video frame: vsync low for lowCycles, then high; the tick is watched throughout.
    task automatic runFrame(input int lowCycles);
        int tickCount;
        int tickPos;
        tickCount = 0;
        tickPos = -1;
        @(negedge clk);
        vsync = 1'b0;
        for (int i = 1; i <= lowCycles + 8; i++) begin
            @(posedge clk);
            #1;
            if (dut.u_tick.frame_tick) begin
                tickCount++;
                if (tickPos < 0) tickPos = i;
            end
            if (i == lowCycles) begin
                @(negedge clk);
                vsync = 1'b1;
            end
        end
        checkOutput("tick_count", 32'(tickCount), 32'd1);
        checkOutput("tick_delay", 32'(tickPos), 32'd3);
        modelFrame(jump_btn, duck_btn, game_over);
    endtask

    initial begin
        int airCount;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkModel("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 3; k++) begin
            runFrame(6);
            checkModel("idle");
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        runFrame(5);
        checkModel("start");
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            runFrame(5);
            checkModel("anim");
            if (k == 6) checkOutput("anim_b", {28'd0, dino_sel}, 32'd2);
            if (k == 12) checkOutput("anim_wrap", {28'd0, dino_sel}, 32'd1);
        end

        applyStimulus(1'b1, 1'b0, 1'b0);
        runFrame(5);
        checkModel("launch");
        applyStimulus(1'b0, 1'b0, 1'b0);
        airCount = 0;
        for (int k = 1; k <= 33; k++) begin
            runFrame(4);
            checkModel("jump");
            if (airborne) airCount++;
            if (k == 1) checkOutput("y_t1", dino_y, 32'd284);
            if (k == 3) checkOutput("y_t3", dino_y, 32'd255);
            if (k == 16) checkOutput("peak16", dino_y, 32'd164);
            if (k == 17) checkOutput("peak17", dino_y, 32'd164);
            if (k == 33) checkOutput("land_sel", {28'd0, dino_sel}, 32'd1);
        end
        checkOutput("air_frames", 32'(airCount), 32'd32);

        applyStimulus(1'b1, 1'b1, 1'b0);
        runFrame(5);
        checkModel("jump_prio");
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            runFrame(4);
            checkModel("duck_land");
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        runFrame(5);
        checkModel("unduck");

        applyStimulus(1'b1, 1'b0, 1'b0);
        runFrame(5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) runFrame(4);
        checkOutput("h100", dino_y, 32'd200);
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        modelFrame(1'b0, 1'b0, 1'b1);
        checkOutput("dead_sel", {28'd0, dino_sel}, 32'd10);
        checkOutput("dead_y", dino_y, 32'd200);
        checkOutput("dead_air", {31'd0, airborne}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            runFrame(5);
            checkModel("dead_hold");
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        runFrame(5);
        checkModel("restart");
        checkOutput("restart_y", dino_y, 32'd300);

        applyStimulus(1'b1, 1'b0, 1'b0);
        runFrame(5);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) runFrame(4);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        modelReset();
        checkModel("mid_reset");
        @(negedge clk);
        rst = 1'b1;

        runFrame(300);
        checkModel("long_low");

        for (int k = 0; k < 150; k++) begin
            applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 11) == 0));
            runFrame(int'($urandom_range(4, 20)));
            checkModel("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
